// File: rtl/fetch_queue_if.sv
// Bundle of the fetch-queue handshakes: PC counter control, instruction memory
// read port and the decode-side head-of-queue port.
interface fetch_queue_if #(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  pc_in;
  logic          pc_ce;
  logic          pc_load;
  logic [N-1:0]  pc_d;
  logic [N-1:0]  imem_addr;
  logic [W-1:0]  imem_data;
  logic          branch_req;
  logic [N-1:0]  branch_target;
  logic          dec_ready;
  logic          dec_valid;
  logic [W-1:0]  dec_instr;
  logic [N-1:0]  dec_pc;
  logic [CW-1:0] fifo_count;

  // master is the fetch queue itself; slave is the surrounding core.
  modport master (
    input  pc_in, imem_data, branch_req, branch_target, dec_ready,
    output pc_ce, pc_load, pc_d, imem_addr, dec_valid, dec_instr, dec_pc,
           fifo_count
  );

  modport slave (
    output pc_in, imem_data, branch_req, branch_target, dec_ready,
    input  pc_ce, pc_load, pc_d, imem_addr, dec_valid, dec_instr, dec_pc,
           fifo_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues PC reads to a 1-cycle memory, buffers
// {pc, instr} pairs for decode, and flushes everything on a branch redirect.
module fetch_queue #(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [N-1:0]  r_mem_pc    [DEPTH];
  logic [W-1:0]  r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_infl_v;
  logic [N-1:0]  r_infl_pc;

  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_dec_valid;
  logic          w_redirect;

  // NOTE: combinational logic uses blocking '=' with every signal assigned on
  // every path, so no latch can be inferred; clocked state uses '<=' only.
  always_comb begin
    w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_infl_v};
    w_redirect  = !reset && fq.branch_req;
    w_issue     = !reset && !fq.branch_req && (w_occupancy < DEPTH_C);
    w_dec_valid = !reset && !fq.branch_req && (r_count != '0);
    // A branch kills the returning in-flight read, so it is never pushed.
    w_push      = !reset && !fq.branch_req && r_infl_v;
    w_pop       = w_dec_valid && fq.dec_ready;
  end

  assign fq.pc_ce      = w_issue;
  assign fq.pc_load    = w_redirect;
  assign fq.pc_d       = w_redirect ? fq.branch_target : '0;
  assign fq.imem_addr  = fq.pc_in;
  assign fq.dec_valid  = w_dec_valid;
  assign fq.dec_instr  = r_mem_instr[r_rd_ptr];
  assign fq.dec_pc     = r_mem_pc[r_rd_ptr];
  assign fq.fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_infl_v  <= 1'b0;
      r_infl_pc <= '0;
    end else begin
      r_infl_v <= w_issue;
      if (w_issue) r_infl_pc <= fq.pc_in;

      if (fq.branch_req) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written,
  // because dec_valid depends on the reset-cleared count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_infl_pc;
      r_mem_instr[r_wr_ptr] <= fq.imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table for startup/backpressure,
// scoreboarded decode stream, plus reset, branch and PC-wrap sequences.
module tb_fetch_queue;
  localparam int N     = 8;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WN    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.N(N),  .W(W), .DEPTH(DEPTH)) fq_if ();
  fetch_queue_if #(.N(WN), .W(W), .DEPTH(DEPTH)) wr_if ();

  fetch_queue #(.N(N), .W(W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_if)
  );

  fetch_queue #(.N(WN), .W(W), .DEPTH(DEPTH)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .fq    (wr_if)
  );

  // PC counters and 1-cycle instruction memories (data = 16'hA000 + addr).
  always_ff @(posedge clk) begin
    if (reset)               fq_if.pc_in <= '0;
    else if (fq_if.pc_load)  fq_if.pc_in <= fq_if.pc_d;
    else if (fq_if.pc_ce)    fq_if.pc_in <= fq_if.pc_in + N'(1);
    fq_if.imem_data <= {8'hA0, fq_if.imem_addr};

    if (reset)               wr_if.pc_in <= '0;
    else if (wr_if.pc_load)  wr_if.pc_in <= wr_if.pc_d;
    else if (wr_if.pc_ce)    wr_if.pc_in <= wr_if.pc_in + WN'(1);
    wr_if.imem_data <= {8'hA0, 5'b0, wr_if.imem_addr};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboards: expected decode PCs, pushed by the stimulus, popped on accept.
  logic [N-1:0]  exp_q  [$];
  logic [WN-1:0] wexp_q [$];
  logic [N-1:0]  mon_e;
  logic [WN-1:0] wmon_e;

  always @(negedge clk) begin
    if (fq_if.dec_valid && fq_if.dec_ready && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("dec_pc", 32'(fq_if.dec_pc), 32'(mon_e));
      check("dec_instr", 32'(fq_if.dec_instr), 32'(16'hA000 + 16'(mon_e)));
    end
    if (wr_if.dec_valid && wr_if.dec_ready && wexp_q.size() > 0) begin
      wmon_e = wexp_q.pop_front();
      check("wrap_dec_pc", 32'(wr_if.dec_pc), 32'(wmon_e));
      check("wrap_dec_instr", 32'(wr_if.dec_instr), 32'(16'hA000 + 16'(wmon_e)));
    end
    check("ce_and_load", 32'(fq_if.pc_ce & fq_if.pc_load), 32'd0);
    check("imem_addr", 32'(fq_if.imem_addr), 32'(fq_if.pc_in));
    if (!fq_if.branch_req)
      check("idle_pc_load_d", {23'd0, fq_if.pc_load, fq_if.pc_d}, 32'd0);
  end

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          pc_ce;
    logic          dv;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pc;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  task automatic set_row(input int i, input logic rst, input logic rdy,
                         input logic ce, input logic dv, input int cnt, input int pc);
    vt[i].rst   = rst;
    vt[i].rdy   = rdy;
    vt[i].pc_ce = ce;
    vt[i].dv    = dv;
    vt[i].cnt   = CW'(cnt);
    vt[i].pc    = N'(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size() + wexp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fq_if.branch_req    = 1'b0;
    fq_if.branch_target = '0;
    fq_if.dec_ready     = 1'b0;
    wr_if.branch_req    = 1'b0;
    wr_if.branch_target = '0;
    wr_if.dec_ready     = 1'b1;

    // Startup, fill to DEPTH under backpressure, drain, then steady count=2.
    set_row(0, 1, 0, 0, 0, 0, 0);
    set_row(1, 0, 0, 1, 0, 0, 0);
    set_row(2, 0, 0, 1, 0, 0, 1);
    set_row(3, 0, 0, 1, 1, 1, 2);
    set_row(4, 0, 0, 1, 1, 2, 3);
    set_row(5, 0, 0, 0, 1, 3, 4);
    for (int i = 6; i <= 10; i++) set_row(i, 0, 0, 0, 1, 4, 4);
    set_row(11, 0, 1, 0, 1, 4, 4);
    set_row(12, 0, 1, 1, 1, 3, 4);
    for (int i = 13; i < NV; i++) set_row(i, 0, 1, 1, 1, 2, 5 + (i - 13));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= 12; i++) exp_q.push_back(N'(i));

    for (int i = 0; i < NV; i++) begin
      reset           = vt[i].rst;
      fq_if.dec_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d_pc_ce", i), 32'(fq_if.pc_ce), 32'(vt[i].pc_ce));
      check($sformatf("row%0d_dec_valid", i), 32'(fq_if.dec_valid), 32'(vt[i].dv));
      check($sformatf("row%0d_fifo_count", i), 32'(fq_if.fifo_count), 32'(vt[i].cnt));
      check($sformatf("row%0d_pc", i), 32'(fq_if.pc_in), 32'(vt[i].pc));
      step();
    end
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset with three entries queued, branch also requested.
    fq_if.dec_ready = 1'b0;
    step();
    reset               = 1'b1;
    fq_if.branch_req    = 1'b1;
    fq_if.branch_target = 8'h55;
    @(negedge clk);
    check("pre_reset_count", 32'(fq_if.fifo_count), 32'd3);
    check("rst_pc_ce", 32'(fq_if.pc_ce), 32'd0);
    check("rst_dec_valid", 32'(fq_if.dec_valid), 32'd0);
    check("rst_pc_load_d", {23'd0, fq_if.pc_load, fq_if.pc_d}, 32'd0);
    step();
    reset            = 1'b0;
    fq_if.branch_req = 1'b0;
    fq_if.dec_ready  = 1'b1;
    for (int i = 0; i < 8; i++)  exp_q.push_back(N'(i));
    for (int i = 0; i < 11; i++) wexp_q.push_back(WN'(i % 8));
    @(negedge clk);
    check("post_rst_count", 32'(fq_if.fifo_count), 32'd0);
    check("post_rst_pc", 32'(fq_if.pc_in), 32'd0);
    check("post_rst_issue", 32'(fq_if.pc_ce), 32'd1);
    check("post_rst_t0_valid", 32'(fq_if.dec_valid), 32'd0);
    step();
    @(negedge clk);
    check("post_rst_t1_valid", 32'(fq_if.dec_valid), 32'd0);
    step();
    @(negedge clk);
    check("post_rst_t2_valid", 32'(fq_if.dec_valid), 32'd1);
    wait_drain("stream_and_wrap_drain", 30);

    // Branch with two entries queued and one fetch in flight.
    fq_if.dec_ready = 1'b0;
    step();
    fq_if.dec_ready     = 1'b1;
    fq_if.branch_req    = 1'b1;
    fq_if.branch_target = 8'h40;
    @(negedge clk);
    check("pre_branch_count", 32'(fq_if.fifo_count), 32'd2);
    check("br_pc_load", 32'(fq_if.pc_load), 32'd1);
    check("br_pc_d", 32'(fq_if.pc_d), 32'h40);
    check("br_pc_ce", 32'(fq_if.pc_ce), 32'd0);
    check("br_dec_valid", 32'(fq_if.dec_valid), 32'd0);
    step();
    fq_if.branch_req = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(N'(8'h40 + i));
    @(negedge clk);
    check("br_next_valid", 32'(fq_if.dec_valid), 32'd0);
    check("br_next_count", 32'(fq_if.fifo_count), 32'd0);
    check("br_next_pc", 32'(fq_if.pc_in), 32'h40);
    wait_drain("branch_drain", 30);

    // Back-to-back redirects: only the last target survives.
    fq_if.branch_req    = 1'b1;
    fq_if.branch_target = 8'h80;
    @(negedge clk);
    check("b2b_first_pc_d", 32'(fq_if.pc_d), 32'h80);
    step();
    fq_if.branch_target = 8'h90;
    @(negedge clk);
    check("b2b_second_pc_d", 32'(fq_if.pc_d), 32'h90);
    check("b2b_second_valid", 32'(fq_if.dec_valid), 32'd0);
    step();
    fq_if.branch_req = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(N'(8'h90 + i));
    @(negedge clk);
    check("b2b_count", 32'(fq_if.fifo_count), 32'd0);
    check("b2b_pc", 32'(fq_if.pc_in), 32'h90);
    wait_drain("b2b_drain", 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters, one per line:
- N, 8, PC width; must match the program counter width.
- W, 16, instruction width.
- DEPTH, 4, queue entries; power of two, >= 2.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  N  current program-counter value.
- pc_ce  out  1  increment enable to the program counter.
- pc_load  out  1  load strobe to the program counter.
- pc_d  out  N  load value to the program counter.
- imem_addr  out  N  instruction-memory read address.
- imem_data  in  W  read data, valid exactly 1 cycle after its address.
- branch_req  in  1  redirect request.
- branch_target  in  N  redirect PC.
- dec_ready  in  1  decode accepts the head entry.
- dec_valid  out  1  head entry valid.
- dec_instr  out  W  head instruction.
- dec_pc  out  N  PC of the head instruction.
- fifo_count  out  log2(DEPTH)+1  occupied entries.

REQ-003 The block shall have one clock domain (clk), with synchronous active-high reset.

Function
REQ-004 State: circular queue of DEPTH {pc, instr} entries; rd_ptr/wr_ptr wrap mod DEPTH; count 0..DEPTH; one in-flight slot {infl_v, infl_pc}.

REQ-005 Issue condition: issue = !reset && !branch_req && (count + infl_v < DEPTH), with count taken pre-pop.

REQ-006 pc_ce = issue; imem_addr = pc_in every cycle, combinationally.

REQ-007 On issue, the block shall set infl_v<=1 and infl_pc<=pc_in; with no issue, infl_v<=0.

REQ-008 When infl_v=1 and no flush, the block shall push {infl_pc, imem_data} at wr_ptr and increment wr_ptr.

REQ-009 Fetch latency: PC presented in cycle t appears in the queue at end of t+1; dec_valid is visible in t+2 at the earliest.

REQ-010 dec_valid = (count != 0) && !branch_req; dec_instr and dec_pc = entry at rd_ptr.

REQ-011 Pop on dec_valid && dec_ready: rd_ptr increments.

REQ-012 Simultaneous push and pop shall leave count unchanged.

REQ-013 Branch (branch_req=1):
- pc_load=1, pc_d=branch_target, pc_ce=0.
- Next edge: count<=0, rd_ptr<=wr_ptr, infl_v<=0.
- The in-flight fetch's data is discarded.
- No pop occurs in this cycle.

REQ-014 Without branch_req, pc_load=0 and pc_d=0.

REQ-015 pc_ce and pc_load shall never both be 1.

REQ-016 Back-to-back branch_req cycles: each redirects; the last target wins; no entries are pushed meanwhile.

REQ-017 Full queue (count=DEPTH) with dec_ready=0: no issue, pc_ce=0, and queue contents stable.

REQ-018 PC wrap-around is the counter's; the queue shall store PC values verbatim, with no sign or overflow handling.

REQ-019 fifo_count = count, registered.

Reset
REQ-020 While reset=1 at a rising edge, the block shall clear count, rd_ptr, wr_ptr, infl_v and infl_pc to 0.

REQ-021 While reset=1, the block shall force pc_ce=0, pc_load=0, pc_d=0 and dec_valid=0 combinationally.

REQ-022 Reset asserted mid-fetch shall discard the in-flight fetch and all queued entries; the first issue occurs in the first cycle after reset deasserts.

REQ-023 Reset shall take priority over branch_req, push and pop.

Verification
REQ-024 Streaming:
- Stimulus: reset release; PC counter attached, starts 0; imem_data = {8'hA0, addr}; dec_ready=1.
- Required: dec_pc 0,1,2,... from the 3rd cycle after release; one per cycle; dec_instr = 16'hA000 + pc.

REQ-025 Backpressure:
- Stimulus: dec_ready=0 for 10 cycles, DEPTH=4.
- Required: fifo_count saturates at 4; pc_ce=0 once count+infl_v=4; PC holds at 4.
- Then dec_ready=1: entries 0..3 drain in order, and fetching resumes.

REQ-026 Branch:
- Stimulus: branch_req=1, branch_target=8'h40 for 1 cycle with 2 entries queued and 1 in flight.
- Required: pc_load=1 and pc_d=8'h40 that cycle; dec_valid=0 that cycle and the next; the first post-branch dec_pc is 8'h40; no stale PC ever appears.

REQ-027 Simultaneous push/pop:
- Stimulus: count=2, steady dec_ready=1 while fetching.
- Required: fifo_count stays 2; pointers wrap past DEPTH-1 with no entry lost or duplicated.

REQ-028 Mid-operation reset:
- Stimulus: reset pulsed 1 cycle while count=3.
- Required: fifo_count=0, dec_valid=0, pc_ce=0 during reset; PC restarts at 0; stream resumes as in REQ-024.

REQ-029 PC wrap:
- Stimulus: N=3, free-running.
- Required: dec_pc sequence 6,7,0,1; the queue is unaffected.
